turf_dcm_sequencer: RTL and testbench
=====================================

Name: turf_dcm_sequencer

Overview:
- Sequences and supervises the 125->250 MHz clock-doubling DCM in the TURF clock infrastructure.
- Generates the DCM reset pulse, waits for and qualifies lock, and retries with a timeout on failure.
- Re-resets the DCM automatically on loss of lock or a stopped input clock; counts relock events; latches a fault after repeated failures.
- Runs on CLK33, which does not depend on the doubling DCM, so supervision continues while CLK125/CLK250 are absent.

Parameters:
RESET_CYCLES, 8, CLK33 cycles dcm_reset_o is held high per reset attempt (>= 3 CLKIN periods required)
LOCK_TIMEOUT, 330000, CLK33 cycles allowed in WAIT_LOCK before an attempt fails (~10 ms)
STABLE_CYCLES, 1024, consecutive qualified-lock cycles required before READY
MAX_RETRIES, 7, failed attempts allowed before FAULT (1..255)
CNT_W, 19, width of the shared down-counter; must hold max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)

Ports:
CLK33  in  1  supervisor clock
rst_n_i  in  1  asynchronous active-low reset
dcm_status_i  in  3  [2]=LOCKED, [1]=CLKIN stopped, [0]=phase overflow (unused); asynchronous to CLK33
force_reset_i  in  1  software request; one-cycle pulse restarts the sequence and clears FAULT
dcm_reset_o  out  1  drives the DCM RST input
dcm_ready_o  out  1  high only in READY; gates downstream CLK250 users
dcm_fault_o  out  1  high only in FAULT
state_o  out  3  current state encoding
retry_count_o  out  8  failed attempts since last READY or force
relock_count_o  out  8  READY->RESET transitions caused by lock loss; saturates at 255

Behaviour:
- Synchronisers: dcm_status_i[2:1] pass through 2-flop synchronisers into lock_s and stop_s. Each synchroniser flop resets to 0.
- Reaction latency: an input edge changes state or outputs 3 CLK33 cycles later (2 sync + 1 registered state).
- Asynchronous reset values:
  - state = RESET (0)
  - dcm_reset_o = 1; the DCM is held in reset while the system is in reset
  - counter = RESET_CYCLES-1
  - dcm_ready_o = 0, dcm_fault_o = 0
  - retry_count_o = 0, relock_count_o = 0
- All outputs are registered. dcm_reset_o = 1 in RESET and FAULT, 0 otherwise.
- State encodings: RESET=0, WAIT_LOCK=1, STABLE=2, READY=3, FAULT=4. Other encodings go to RESET.
- RESET: counter decrements each cycle. At 0, go to WAIT_LOCK and load LOCK_TIMEOUT-1. dcm_reset_o is therefore high for exactly RESET_CYCLES cycles.
- WAIT_LOCK:
  - lock_s=1 and stop_s=0: go to STABLE and load STABLE_CYCLES-1.
  - Otherwise, when the counter reaches 0 the attempt fails.
- STABLE:
  - lock_s=0 or stop_s=1: the attempt fails.
  - Counter reaches 0 with the lock still qualified: go to READY and clear retry_count_o.
- Failed attempt: retry_count_o increments.
  - If the new value equals MAX_RETRIES, go to FAULT.
  - Otherwise go to RESET and load RESET_CYCLES-1.
- READY: lock_s=0 or stop_s=1 sends the block to RESET. relock_count_o increments (saturating at 255); retry_count_o is not incremented.
- FAULT: holds indefinitely with dcm_reset_o=1. It is left only via force_reset_i.
- force_reset_i:
  - Highest priority, effective in any state including mid-RESET.
  - Next state is RESET, counter reloads to RESET_CYCLES-1, retry_count_o clears.
  - relock_count_o is unchanged. A lock loss in the same cycle does not increment relock_count_o.
- Simultaneous events:
  - WAIT_LOCK, lock arriving on the timeout cycle: lock wins and the block enters STABLE.
  - STABLE, lock dropping on the final cycle: the attempt fails.
- dcm_status_i[0] is ignored.

Test Plan (RESET_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=16, MAX_RETRIES=3):
- Power-up: release rst_n_i; LOCKED rises 50 cycles later -> dcm_reset_o high for 4 cycles after reset release; state sequence 0->1->2->3; dcm_ready_o rises 3+16 cycles after LOCKED; retry_count_o=0.
- Timeout retry: LOCKED held low -> 3 attempts, each with a 4-cycle reset pulse followed by 100 cycles in WAIT_LOCK; then state_o=4, dcm_fault_o=1, dcm_reset_o=1, retry_count_o=3; remains there for 1000 cycles.
- Fault recovery: from FAULT, pulse force_reset_i with LOCKED=1 -> RESET next cycle, retry_count_o=0, READY after 4+1+16 cycles.
- Lock loss: in READY, drop LOCKED for 1 cycle -> 3 cycles later state_o=0, dcm_ready_o=0, relock_count_o increments by 1; repeat 300 times -> relock_count_o saturates at 255.
- Stable qualification glitch: drop LOCKED during STABLE cycle 10 -> state_o=0, retry_count_o=1, no READY; CLKIN-stopped asserted in READY -> same response as lock loss.
- Mid-sequence reset: assert rst_n_i low during WAIT_LOCK -> all outputs take reset values immediately; dcm_reset_o=1 asynchronously.

Source files
------------

// File: rtl/turf_dcm_sequencer.sv
// Supervisor for the 125->250 MHz doubling DCM: reset pulse, lock qualification,
// timed retries, automatic re-reset on lock loss and a latched fault after repeated failures.
module turf_dcm_sequencer #(
    parameter int RESET_CYCLES  = 8,
    parameter int LOCK_TIMEOUT  = 330000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int CNT_W         = 19
) (
    input  logic       CLK33,
    input  logic       rst_n_i,
    input  logic [2:0] dcm_status_i,
    input  logic       force_reset_i,
    output logic       dcm_reset_o,
    output logic       dcm_ready_o,
    output logic       dcm_fault_o,
    output logic [2:0] state_o,
    output logic [7:0] retry_count_o,
    output logic [7:0] relock_count_o
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_READY     = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LOAD    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       MAX_RET     = 8'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       relock_q, relock_d;
    logic             dcm_reset_q, dcm_reset_d;
    logic             dcm_ready_q, dcm_ready_d;
    logic             dcm_fault_q, dcm_fault_d;
    logic [1:0]       lock_sync_q, lock_sync_d;
    logic [1:0]       stop_sync_q, stop_sync_d;
    logic             lock_s, stop_s, lock_ok, fail;
    logic             unused_ovf;

    // Phase-overflow status has no role in supervision.
    assign unused_ovf = dcm_status_i[0];

    assign lock_sync_d = {lock_sync_q[0], dcm_status_i[2]};
    assign stop_sync_d = {stop_sync_q[0], dcm_status_i[1]};
    assign lock_s      = lock_sync_q[1];
    assign stop_s      = stop_sync_q[1];
    assign lock_ok     = lock_s && !stop_s;

    always_ff @(posedge CLK33 or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_RESET;
            cnt_q       <= RST_LOAD;
            retry_q     <= '0;
            relock_q    <= '0;
            dcm_reset_q <= 1'b1;
            dcm_ready_q <= 1'b0;
            dcm_fault_q <= 1'b0;
            lock_sync_q <= '0;
            stop_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            relock_q    <= relock_d;
            dcm_reset_q <= dcm_reset_d;
            dcm_ready_q <= dcm_ready_d;
            dcm_fault_q <= dcm_fault_d;
            lock_sync_q <= lock_sync_d;
            stop_sync_q <= stop_sync_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        fail     = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = TMO_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is checked before the timeout so a lock on the last cycle still wins.
                if (lock_ok) begin
                    state_d = ST_STABLE;
                    cnt_d   = STB_LOAD;
                end else if (cnt_q == '0) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (!lock_ok) begin
                    fail = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = ST_READY;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_READY: begin
                if (!lock_ok) begin
                    state_d = ST_RESET;
                    cnt_d   = RST_LOAD;
                    if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = RST_LOAD;
            end
        endcase

        if (fail) begin
            retry_d = retry_q + 8'd1;
            if (retry_d == MAX_RET) begin
                state_d = ST_FAULT;
            end else begin
                state_d = ST_RESET;
                cnt_d   = RST_LOAD;
            end
        end

        // Software restart overrides everything, including a simultaneous lock loss.
        if (force_reset_i) begin
            state_d  = ST_RESET;
            cnt_d    = RST_LOAD;
            retry_d  = '0;
            relock_d = relock_q;
        end
    end

    always_comb begin
        dcm_reset_d = (state_d == ST_RESET) || (state_d == ST_FAULT);
        dcm_ready_d = (state_d == ST_READY);
        dcm_fault_d = (state_d == ST_FAULT);
    end

    assign dcm_reset_o    = dcm_reset_q;
    assign dcm_ready_o    = dcm_ready_q;
    assign dcm_fault_o    = dcm_fault_q;
    assign state_o        = state_q;
    assign retry_count_o  = retry_q;
    assign relock_count_o = relock_q;

endmodule

// File: tb/tb_turf_dcm_sequencer.sv
// Directed bench for turf_dcm_sequencer with short timing parameters.
module tb_turf_dcm_sequencer;

    logic       clk;
    logic       rst_n;
    logic [2:0] status;
    logic       force_rst;
    logic       dcm_reset;
    logic       dcm_ready;
    logic       dcm_fault;
    logic [2:0] state;
    logic [7:0] retry_cnt;
    logic [7:0] relock_cnt;

    int n_checks;
    int n_err;
    int relock_exp;

    turf_dcm_sequencer #(
        .RESET_CYCLES (4),
        .LOCK_TIMEOUT (100),
        .STABLE_CYCLES(16),
        .MAX_RETRIES  (3),
        .CNT_W        (19)
    ) dut (
        .CLK33         (clk),
        .rst_n_i       (rst_n),
        .dcm_status_i  (status),
        .force_reset_i (force_rst),
        .dcm_reset_o   (dcm_reset),
        .dcm_ready_o   (dcm_ready),
        .dcm_fault_o   (dcm_fault),
        .state_o       (state),
        .retry_count_o (retry_cnt),
        .relock_count_o(relock_cnt)
    );

    initial clk = 1'b0;
    always #15 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        status    = 3'b000;
        force_rst = 1'b0;
        tick(3);
        chk("rst_state", state, 0);
        chk("rst_dcm_reset", dcm_reset, 1);
        chk("rst_ready", dcm_ready, 0);
        chk("rst_fault", dcm_fault, 0);
        chk("rst_retry", retry_cnt, 0);
        chk("rst_relock", relock_cnt, 0);

        // Power-up: 4-cycle reset pulse, lock 50 cycles after release.
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            chk("pu_reset_state", state, 0);
            chk("pu_reset_pulse", dcm_reset, 1);
        end
        tick(1);
        chk("pu_wait_state", state, 1);
        chk("pu_pulse_end", dcm_reset, 0);
        tick(46);
        status = 3'b100;
        tick(2);
        chk("pu_sync_lat", state, 1);
        tick(1);
        chk("pu_stable", state, 2);
        tick(15);
        chk("pu_stable_end", state, 2);
        chk("pu_not_ready", dcm_ready, 0);
        tick(1);
        chk("pu_ready_state", state, 3);
        chk("pu_ready", dcm_ready, 1);
        chk("pu_retry", retry_cnt, 0);

        // Single-cycle lock loss in READY.
        status = 3'b000;
        tick(1);
        status = 3'b100;
        tick(1);
        chk("ll_latency", state, 3);
        tick(1);
        chk("ll_state", state, 0);
        chk("ll_ready", dcm_ready, 0);
        chk("ll_relock", relock_cnt, 1);
        chk("ll_reset", dcm_reset, 1);
        tick(20);
        chk("ll_stable", state, 2);
        tick(1);
        chk("ll_back_ready", state, 3);

        // Lock glitch during the 10th STABLE cycle fails the attempt.
        status = 3'b000;
        tick(1);
        status = 3'b100;
        tick(2);
        chk("sg_relock", relock_cnt, 2);
        tick(5);
        chk("sg_in_stable", state, 2);
        tick(7);
        status = 3'b000;
        tick(1);
        status = 3'b100;
        tick(1);
        chk("sg_still_stable", state, 2);
        tick(1);
        chk("sg_failed", state, 0);
        chk("sg_retry", retry_cnt, 1);
        chk("sg_no_ready", dcm_ready, 0);
        chk("sg_relock_hold", relock_cnt, 2);
        tick(20);
        chk("sg_restable", state, 2);
        chk("sg_retry_kept", retry_cnt, 1);
        tick(1);
        chk("sg_ready", state, 3);
        chk("sg_retry_clr", retry_cnt, 0);

        // CLKIN stopped while READY.
        status = 3'b110;
        tick(1);
        status = 3'b100;
        tick(2);
        chk("stop_state", state, 0);
        chk("stop_relock", relock_cnt, 3);
        tick(21);
        chk("stop_ready", state, 3);

        // Force in READY: restart without counting a relock.
        force_rst = 1'b1;
        tick(1);
        force_rst = 1'b0;
        chk("frc_state", state, 0);
        chk("frc_reset", dcm_reset, 1);
        chk("frc_relock", relock_cnt, 3);
        tick(20);
        chk("frc_stable", state, 2);
        tick(1);
        chk("frc_ready", state, 3);

        // Force coinciding with a lock loss.
        status = 3'b000;
        tick(2);
        force_rst = 1'b1;
        status = 3'b100;
        tick(1);
        force_rst = 1'b0;
        chk("frcll_state", state, 0);
        chk("frcll_relock", relock_cnt, 3);
        chk("frcll_retry", retry_cnt, 0);
        tick(21);
        chk("frcll_ready", state, 3);

        // Lock held low: three timed-out attempts then FAULT.
        status = 3'b000;
        tick(3);
        chk("to_state", state, 0);
        chk("to_relock", relock_cnt, 4);
        tick(103);
        chk("to_wait1_end", state, 1);
        tick(1);
        chk("to_fail1", state, 0);
        chk("to_retry1", retry_cnt, 1);
        chk("to_reset1", dcm_reset, 1);
        tick(3);
        chk("to_pulse2", dcm_reset, 1);
        tick(1);
        chk("to_wait2", state, 1);
        chk("to_pulse2_end", dcm_reset, 0);
        tick(99);
        chk("to_wait2_end", state, 1);
        tick(1);
        chk("to_fail2", state, 0);
        chk("to_retry2", retry_cnt, 2);
        tick(103);
        chk("to_wait3_end", state, 1);
        tick(1);
        chk("to_fault_state", state, 4);
        chk("to_fault", dcm_fault, 1);
        chk("to_fault_reset", dcm_reset, 1);
        chk("to_retry3", retry_cnt, 3);
        tick(1000);
        chk("to_hold_state", state, 4);
        chk("to_hold_fault", dcm_fault, 1);
        chk("to_hold_reset", dcm_reset, 1);
        chk("to_hold_relock", relock_cnt, 4);

        // Recovery from FAULT with lock present.
        status = 3'b100;
        tick(3);
        chk("rec_still_fault", state, 4);
        force_rst = 1'b1;
        tick(1);
        force_rst = 1'b0;
        chk("rec_state", state, 0);
        chk("rec_retry", retry_cnt, 0);
        chk("rec_fault", dcm_fault, 0);
        chk("rec_reset", dcm_reset, 1);
        tick(20);
        chk("rec_stable", state, 2);
        tick(1);
        chk("rec_ready_state", state, 3);
        chk("rec_ready", dcm_ready, 1);

        // Repeated lock losses saturate the relock counter.
        relock_exp = 4;
        for (int i = 0; i < 300; i++) begin
            status = 3'b000;
            tick(1);
            status = 3'b100;
            tick(2);
            if (relock_exp < 255) relock_exp++;
            chk("sat_state", state, 0);
            chk("sat_relock", relock_cnt, relock_exp);
            tick(21);
            chk("sat_ready", state, 3);
        end
        chk("sat_final", relock_cnt, 255);

        // Asynchronous reset in the middle of WAIT_LOCK.
        status = 3'b000;
        tick(10);
        chk("mr_wait", state, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_state", state, 0);
        chk("mr_dcm_reset", dcm_reset, 1);
        chk("mr_ready", dcm_ready, 0);
        chk("mr_fault", dcm_fault, 0);
        chk("mr_retry", retry_cnt, 0);
        chk("mr_relock", relock_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
